uart_tx_buf: RTL and testbench

Buffered UART transmitter: the output-side counterpart of the core's UART receive path. Accepts bytes from the CPU core over a valid/ready port, queues them in a small FIFO, and serialises each as an 8N1 frame on `txd`, LSB first, with back-to-back frames and no idle gap. It sits between the core's output register and the board's TX pin.

---
 rtl/uart_pkg.sv | 10 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_tx_buf.sv | 101 ++++++++++
 tb/tb_uart_tx_buf.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        UART_START_BIT = 1'b0;
  localparam logic        UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset; pushes when full and pops when
// empty are ignored.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW-1:0] AddrLast = AddrW'(Depth - 1);
  localparam logic [AddrW:0]   CountFull = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CountFull);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == AddrLast) ? '0 : wptr_q + AddrW'(1);
      if (do_pop)  rptr_q <= (rptr_q == AddrLast) ? '0 : rptr_q + AddrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AddrW + 1)'(1);
        2'b01:   count_q <= count_q - (AddrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a start/data/stop shifter with
// back-to-back frames.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 145,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        txd,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned BaudW = $clog2(CLK_PER_BIT);
  localparam int unsigned BitW  = $clog2(UART_DATA_BITS);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(UART_DATA_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [BaudW-1:0]          baud_q, baud_d;
  logic [BitW-1:0]           bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      txd_q, txd_d;
  logic                      bit_end;
  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [7:0]                fifo_rdata;

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .push_i  (tx_valid && tx_ready),
    .wdata_i (tx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign txd      = txd_q;
  assign tx_busy  = (state_q != IDLE) || (fifo_count != '0);
  assign bit_end  = (baud_q == BaudLast);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= UART_STOP_BIT;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && (bit_q == BitLast)) state_d = STOP;
      STOP:  if (bit_end) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Every entry into START loads a fresh byte, so the pop is exactly that transition.
  always_comb begin
    fifo_pop = (state_d == START) && (state_q != START);
    baud_d   = '0;
    bit_d    = bit_q;
    shift_d  = shift_q;
    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + BaudW'(1);
    if (fifo_pop) shift_d = fifo_rdata;
    if (state_q == START) bit_d = '0;
    if ((state_q == DATA) && bit_end) begin
      shift_d = shift_q >> 1;
      bit_d   = (bit_q == BitLast) ? '0 : bit_q + BitW'(1);
    end
    // txd is registered, so it follows the state being entered.
    unique case (state_d)
      START:   txd_d = UART_START_BIT;
      DATA:    txd_d = shift_d[0];
      default: txd_d = UART_STOP_BIT;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: frame-level reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_uart_tx_buf;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, txd, tx_busy;
  logic [2:0] fifo_count;

  uart_tx_buf #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a byte queue and the position within the frame being sent.
  byte unsigned m_q[$];
  logic [7:0]   m_cur;
  bit           m_active = 1'b0;
  int           m_t = 0;

  function automatic logic m_txd();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  initial begin
    bit acc;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rstn) begin
        m_q.delete();
        m_active = 1'b0;
        m_t = 0;
      end else begin
        acc = tx_valid && (m_q.size() < DEPTH);
        if (m_active && m_t != FRAME - 1) m_t++;
        else if (m_q.size() != 0) begin
          m_cur = m_q.pop_front();
          m_active = 1'b1;
          m_t = 0;
        end else m_active = 1'b0;
        if (acc) m_q.push_back(tx_data);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("txd", txd, m_txd());
        chk("tx_ready", tx_ready, m_q.size() < DEPTH);
        chk("tx_busy", tx_busy, m_active || (m_q.size() != 0));
        chk("fifo_count", fifo_count, m_q.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the byte until accepted; returns the index of the accepting edge.
  task automatic send(input logic [7:0] b, output int acc_cyc);
    int   g = 0;
    logic r;
    tx_data  = b;
    tx_valid = 1'b1;
    acc_cyc  = -1;
    forever begin
      r = tx_ready;
      tick();
      if (r) begin
        acc_cyc = cyc;
        break;
      end
      if (++g > 500) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    tx_valid = 1'b0;
  endtask

  // Decodes one frame from the line, sampling mid-bit; st is the first low cycle.
  task automatic rx_byte(output logic [7:0] b, output int st);
    int g = 0;
    b  = '0;
    st = -1;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) break;
      if (++g > 300) begin
        chk("rx_start_timeout", 0, 1);
        return;
      end
    end
    st = cyc;
    repeat (2) @(negedge clk);
    chk("rx_start_bit", txd, 0);
    for (int j = 0; j < 8; j++) begin
      repeat (CPB) @(negedge clk);
      b[j] = txd;
    end
    repeat (CPB) @(negedge clk);
    chk("rx_stop_bit", txd, 1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (tx_busy !== 1'b0) begin
      tick();
      if (++g > 1000) begin
        chk("idle_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [0:44] exp_txd;
    logic [7:0]  b1, b2;
    logic [7:0]  got [6];
    int          n, n2, s1, s2, a, pk, lows;
    int          acc [6];

    rstn = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    repeat (3) tick();
    chk("rst_txd", txd, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    rstn = 1'b1;
    check_en = 1'b1;
    repeat (2) tick();

    // Single 0x55: index k is the line after edge N+k.
    exp_txd = 45'b1_0000_1111_0000_1111_0000_1111_0000_1111_0000_1111_1111;
    send(8'h55, n);
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      chk("t55_txd", txd, exp_txd[k]);
      chk("t55_busy", tx_busy, k <= 40);
    end
    wait_idle();

    // Two contiguous frames.
    fork
      begin
        send(8'hA5, n);
        send(8'h3C, n2);
      end
      begin
        rx_byte(b1, s1);
        rx_byte(b2, s2);
      end
    join
    chk("pair_byte0", b1, 8'hA5);
    chk("pair_byte1", b2, 8'h3C);
    chk("pair_latency", s1 - n, 1);
    chk("pair_gap", s2 - s1, 40);
    wait_idle();

    // Overfill from idle.
    fork
      begin
        for (int i = 0; i < 6; i++) send(8'(i + 1), acc[i]);
      end
      begin
        for (int i = 0; i < 6; i++) rx_byte(got[i], s1);
      end
      begin
        pk = 0;
        repeat (60) begin
          @(negedge clk);
          if (fifo_count > pk) pk = fifo_count;
        end
      end
    join
    chk("fill_peak", pk, 4);
    chk("fill_fifth_edge", acc[4] - acc[0], 4);
    chk("fill_sixth_edge", acc[5] - acc[0], 42);
    for (int i = 0; i < 6; i++) chk("fill_order", got[i], i + 1);
    wait_idle();

    // Push on the pop edge with two bytes queued.
    send(8'h11, n);
    send(8'h22, a);
    send(8'h33, a);
    while (cyc < n + 40) tick();
    chk("pp_count_before", fifo_count, 2);
    send(8'h44, a);
    chk("pp_accept_edge", a - n, 41);
    @(negedge clk);
    chk("pp_count_after", fifo_count, 2);
    chk("pp_next_start", txd, 0);
    wait_idle();

    // Reset during DATA bit 3 of 0x00.
    send(8'h00, n);
    while (cyc < n + 17) tick();
    chk("rst_mid_low", txd, 0);
    rstn = 1'b0;
    tick();
    chk("rst_mid_txd", txd, 1);
    chk("rst_mid_count", fifo_count, 0);
    rstn = 1'b1;
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("rst_line_quiet", lows, 0);
    chk("rst_not_busy", tx_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
